mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data Memory between the fetch path (PC-addressed) and the load/store path (ALU-result-addressed), so the processor can run from one unified memory.
- Grants one transaction at a time, tracks in-flight reads over a fixed read latency, and routes returned data and valid pulses to the owning requester.
- Data port has priority; a streak limit prevents fetch starvation.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
READ_LAT, 1, cycles from grant to mem_rdata valid; legal range 1..7
STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; legal range 1..15

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request (level)
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rdata  out  DATA_W  fetch read data
if_valid  out  1  if_rdata valid (1-cycle pulse)
d_req  in  1  data request (level)
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle
d_rdata  out  DATA_W  load data
d_valid  out  1  d_rdata valid (1-cycle pulse, reads only)
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after mem_en with mem_we=0
busy  out  1  read in flight

Behaviour:
- Requests are level; each requester holds req, addr, we and wdata stable until its gnt is sampled high. Deasserting req before gnt is legal and withdraws the request.
- States: IDLE, WAIT.
  - IDLE: accepts a new grant.
  - WAIT: read outstanding; down-counter cnt loaded with READ_LAT at the read grant.
- Grant-eligible cycle: state==IDLE, or state==WAIT and cnt==1 (back-to-back issue in the cycle read data returns).
- Arbitration (combinational, in eligible cycles only):
  - Both requesting and streak<STARVE_LIMIT: data wins.
  - Both requesting and streak==STARVE_LIMIT: fetch wins.
  - Otherwise the single requester wins.
  - At most one of if_gnt/d_gnt is high per cycle.
- streak counter:
  - +1 on each d_gnt while if_req is high.
  - Cleared on if_gnt, or on any cycle with if_req low.
  - Saturates at STARVE_LIMIT.
- Grant cycle drives mem_en=1 and mem_addr from the winner. mem_we=d_we and mem_wdata=d_wdata for a data grant; mem_we=0 for a fetch grant.
- Non-grant cycles: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Write grant: transaction completes in the grant cycle, no valid pulse. The next state is IDLE unless a read is still returning.
- Read grant:
  - Next state WAIT, cnt=READ_LAT; a registered owner bit records fetch or data.
  - In WAIT, cnt decrements each cycle. When cnt==1, mem_rdata is valid: assert owner's valid and drive owner's rdata=mem_rdata in that cycle.
  - Next state: IDLE, or WAIT again if a new read is granted in the same cycle.
- A write granted in a cnt==1 cycle is legal (the memory accepts a write alongside the returning read).
- busy=1 whenever state==WAIT.
- Non-owner rdata is 0; valid pulses never overlap.
- Reset (any time, including mid-read):
  - state=IDLE, cnt=0, streak=0, owner=fetch.
  - All outputs 0: gnts, valids, rdata, mem_*, busy.
  - The in-flight read is discarded; no valid pulse is issued after reset.
- Latency: request to gnt is 0 cycles when eligible. Gnt to valid is READ_LAT cycles.
- Peak read throughput is 1 per READ_LAT cycles.

Test Plan:
- Reset, then if_req=1, if_addr=0x0: if_gnt=1 in the same cycle, mem_en=1, mem_addr=0x0. With READ_LAT=1 and mem_rdata=0xE3A01005, the next cycle gives if_valid=1, if_rdata=0xE3A01005, d_valid=0.
- d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, if_req=0: d_gnt=1, mem_we=1, mem_wdata=0xDEADBEEF, busy stays 0, no d_valid.
- if_req and d_req (read) held continuously, STARVE_LIMIT=4: grant order D,D,D,D,F,D,D,D,D,F; every read returns valid to the correct owner READ_LAT cycles later.
- READ_LAT=3, continuous fetch reads to 0x0, 0x4, 0x8: gnts at cycles 0, 3, 6; if_valid at cycles 3, 6, 9; busy high from cycle 1 through 9.
- Data read granted with READ_LAT=3; assert reset one cycle later, release two cycles later: no d_valid ever pulses, and all outputs are 0 during reset.
- d_req withdrawn while a read is in WAIT with cnt>1: no d_gnt is issued and mem_en stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch and load/store paths.
// Data has priority; a bounded data streak guarantees fetch forward progress.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [2:0] LAT   = 3'(READ_LAT);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] streak_q, streak_d;
  logic       owner_q, owner_d;  // 1 = data port owns the outstanding read

  logic returning;
  logic eligible;
  logic rd_grant;

  // Read data lands when the counter reaches 1; that cycle may also issue.
  assign returning = (state_q == WAIT) && (cnt_q == 3'd1);
  assign eligible  = !reset && ((state_q == IDLE) || returning);
  assign rd_grant  = if_gnt || (d_gnt && !d_we);
  assign busy      = (state_q == WAIT);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_valid  = 1'b0;
    d_valid   = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (eligible) begin
      if (if_req && d_req) begin
        d_gnt  = (streak_q < LIMIT);
        if_gnt = !(streak_q < LIMIT);
      end else begin
        d_gnt  = d_req;
        if_gnt = if_req;
      end
    end

    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end

    if (returning) begin
      if (owner_q) begin
        d_valid = 1'b1;
        d_rdata = mem_rdata;
      end else begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    streak_d = streak_q;

    if (rd_grant) begin
      state_d = WAIT;
      cnt_d   = LAT;
      owner_d = d_gnt;
    end else if ((state_q == WAIT) && (cnt_q > 3'd1)) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end

    // The streak only counts data wins that actually held a fetch off.
    if (!if_req || if_gnt) begin
      streak_d = 4'd0;
    end else if (d_gnt && (streak_q < LIMIT)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      streak_q <= 4'd0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at READ_LAT=1, one at READ_LAT=3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // READ_LAT=1 instance
  logic        if_req1, if_gnt1, if_valid1, d_req1, d_we1, d_gnt1, d_valid1;
  logic        mem_en1, mem_we1, busy1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  // READ_LAT=3 instance
  logic        if_req3, if_gnt3, if_valid3, d_req3, d_we3, d_gnt3, d_valid3;
  logic        mem_en3, mem_we3, busy3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3;
  logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
  logic [31:0] p1, p2;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .STARVE_LIMIT(4)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rdata(d_rdata1), .d_valid(d_valid1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3), .STARVE_LIMIT(4)) u_lat3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rdata(if_rdata3), .if_valid(if_valid3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rdata(d_rdata3), .d_valid(d_valid3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return (a == 32'h0) ? 32'hE3A01005 : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Memory models: returned word depends only on the read address.
  always @(posedge clk) begin
    mem_rdata1 <= (mem_en1 && !mem_we1) ? data_fn(mem_addr1) : 32'hBAD0BAD0;
    p1         <= (mem_en3 && !mem_we3) ? data_fn(mem_addr3) : 32'hBAD0BAD0;
    p2         <= p1;
    mem_rdata3 <= p2;
  end

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_zero(input string t, input logic ig, input logic dg, input logic iv,
                          input logic dv, input logic [31:0] ir, input logic [31:0] dr,
                          input logic me, input logic mw, input logic [31:0] ma,
                          input logic [31:0] mwd, input logic b);
    chk1({t, "_if_gnt"}, ig, 1'b0);
    chk1({t, "_d_gnt"}, dg, 1'b0);
    chk1({t, "_if_valid"}, iv, 1'b0);
    chk1({t, "_d_valid"}, dv, 1'b0);
    chk({t, "_if_rdata"}, ir, 32'h0);
    chk({t, "_d_rdata"}, dr, 32'h0);
    chk1({t, "_mem_en"}, me, 1'b0);
    chk1({t, "_mem_we"}, mw, 1'b0);
    chk({t, "_mem_addr"}, ma, 32'h0);
    chk({t, "_mem_wdata"}, mwd, 32'h0);
    chk1({t, "_busy"}, b, 1'b0);
  endtask

  task automatic drv1(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    if_req1 = ir; if_addr1 = ia; d_req1 = dr; d_we1 = dwe; d_addr1 = da; d_wdata1 = dwd;
    #1;
  endtask

  task automatic drv3(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    if_req3 = ir; if_addr3 = ia; d_req3 = dr; d_we3 = dwe; d_addr3 = da; d_wdata3 = dwd;
    #1;
  endtask

  // Monitor: pops the scoreboard whenever either instance pulses a valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (if_valid1 || d_valid1) begin
        chk1("l1_valid_overlap", if_valid1 & d_valid1, 1'b0);
        if (q1.size() == 0) chk1("l1_spurious_valid", if_valid1 | d_valid1, 1'b0);
        else begin
          e = q1.pop_front();
          chk1("l1_owner", d_valid1, e.is_d);
          chk("l1_rdata", d_valid1 ? d_rdata1 : if_rdata1, e.data);
          chk("l1_nonowner_rdata", d_valid1 ? if_rdata1 : d_rdata1, 32'h0);
          chk("l1_valid_cycle", cyc, e.cyc);
        end
      end
      if (if_valid3 || d_valid3) begin
        chk1("l3_valid_overlap", if_valid3 & d_valid3, 1'b0);
        if (q3.size() == 0) chk1("l3_spurious_valid", if_valid3 | d_valid3, 1'b0);
        else begin
          e = q3.pop_front();
          chk1("l3_owner", d_valid3, e.is_d);
          chk("l3_rdata", d_valid3 ? d_rdata3 : if_rdata3, e.data);
          chk("l3_nonowner_rdata", d_valid3 ? if_rdata3 : d_rdata3, 32'h0);
          chk("l3_valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string       pat;
    logic        ed;
    logic [31:0] ia, da;
    int          ng;

    if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
    if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;

    // Outputs held at zero during reset even with both requests asserted.
    drv1(1, 32'h8, 1, 1, 32'h10, 32'h1234);
    drv3(1, 32'h8, 1, 0, 32'h10, 32'h0);
    chk_zero("rst_l1", if_gnt1, d_gnt1, if_valid1, d_valid1, if_rdata1, d_rdata1,
             mem_en1, mem_we1, mem_addr1, mem_wdata1, busy1);
    chk_zero("rst_l3", if_gnt3, d_gnt3, if_valid3, d_valid3, if_rdata3, d_rdata3,
             mem_en3, mem_we3, mem_addr3, mem_wdata3, busy3);
    @(negedge clk);
    reset = 0;
    if_req1 = 0; d_req1 = 0; d_we1 = 0; if_req3 = 0; d_req3 = 0;

    // Fetch read, zero-cycle grant, data one cycle later.
    drv1(1, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t1_if_gnt", if_gnt1, 1'b1);
    chk1("t1_d_gnt", d_gnt1, 1'b0);
    chk1("t1_mem_en", mem_en1, 1'b1);
    chk1("t1_mem_we", mem_we1, 1'b0);
    chk("t1_mem_addr", mem_addr1, 32'h0);
    q1.push_back('{is_d: 1'b0, data: 32'hE3A01005, cyc: cyc + 1});
    drv1(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t1_busy_wait", busy1, 1'b1);
    chk1("t1_no_reissue", mem_en1, 1'b0);
    drv1(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t1_busy_idle", busy1, 1'b0);

    // Data write: completes in the grant cycle, never busy, no valid.
    drv1(0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF);
    chk1("t2_d_gnt", d_gnt1, 1'b1);
    chk1("t2_if_gnt", if_gnt1, 1'b0);
    chk1("t2_mem_en", mem_en1, 1'b1);
    chk1("t2_mem_we", mem_we1, 1'b1);
    chk("t2_mem_addr", mem_addr1, 32'h40);
    chk("t2_mem_wdata", mem_wdata1, 32'hDEADBEEF);
    drv1(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t2_busy", busy1, 1'b0);
    chk1("t2_mem_en_after", mem_en1, 1'b0);

    // Both ports reading continuously: four data wins, then one fetch.
    pat = "DDDDFDDDDF";
    ia = 32'h200;
    da = 32'h100;
    for (int i = 0; i < 10; i++) begin
      drv1(1, ia, 1, 0, da, 32'h0);
      ed = (pat[i] == "D");
      chk1("t3_d_gnt", d_gnt1, ed);
      chk1("t3_if_gnt", if_gnt1, !ed);
      chk("t3_mem_addr", mem_addr1, ed ? da : ia);
      chk1("t3_mem_we", mem_we1, 1'b0);
      q1.push_back('{is_d: ed, data: data_fn(ed ? da : ia), cyc: cyc + 1});
      if (ed) da = da + 32'h4;
      else ia = ia + 32'h4;
    end
    drv1(0, 32'h0, 0, 0, 32'h0, 32'h0);
    drv1(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t3_busy_end", busy1, 1'b0);

    // READ_LAT=3 back-to-back fetches: grants at 0,3,6, busy 1..9.
    ng = 0;
    for (int c = 0; c <= 10; c++) begin
      drv3(c <= 6, 32'(4 * ng), 0, 0, 32'h0, 32'h0);
      ed = (c % 3 == 0) && (c <= 6);
      chk1("t4_if_gnt", if_gnt3, ed);
      chk1("t4_busy", busy3, (c >= 1) && (c <= 9));
      if (ed) begin
        chk("t4_mem_addr", mem_addr3, 32'(4 * ng));
        q3.push_back('{is_d: 1'b0, data: data_fn(32'(4 * ng)), cyc: cyc + 3});
        ng++;
      end
    end

    // Data request appears and is withdrawn while a read is outstanding.
    drv3(0, 32'h0, 1, 0, 32'h80, 32'h0);
    chk1("t5_d_gnt", d_gnt3, 1'b1);
    chk("t5_mem_addr", mem_addr3, 32'h80);
    q3.push_back('{is_d: 1'b1, data: data_fn(32'h80), cyc: cyc + 3});
    drv3(0, 32'h0, 1, 0, 32'h84, 32'h0);
    chk1("t5_hold_gnt", d_gnt3, 1'b0);
    chk1("t5_hold_mem_en", mem_en3, 1'b0);
    drv3(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t5_withdrawn_gnt", d_gnt3, 1'b0);
    chk1("t5_withdrawn_mem_en", mem_en3, 1'b0);
    drv3(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t5_return_mem_en", mem_en3, 1'b0);
    drv3(0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk1("t5_busy_end", busy3, 1'b0);

    // Reset one cycle after a data read grant discards the read.
    drv3(0, 32'h0, 1, 0, 32'hC0, 32'h0);
    chk1("t6_d_gnt", d_gnt3, 1'b1);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      reset = 1;
      if_req3 = 1; if_addr3 = 32'h44; d_req3 = 1; d_addr3 = 32'hC4;
      #1;
      chk_zero("t6_rst", if_gnt3, d_gnt3, if_valid3, d_valid3, if_rdata3, d_rdata3,
               mem_en3, mem_we3, mem_addr3, mem_wdata3, busy3);
    end
    @(negedge clk);
    reset = 0;
    if_req3 = 0; d_req3 = 0;
    for (int r = 0; r < 4; r++) begin
      drv3(0, 32'h0, 0, 0, 32'h0, 32'h0);
      chk1("t6_no_d_valid", d_valid3, 1'b0);
      chk1("t6_no_if_valid", if_valid3, 1'b0);
    end

    chk1("q1_drained", q1.size() == 0, 1'b1);
    chk1("q3_drained", q3.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
